// File: rtl/nibble_rsp_deserializer_if.sv
// Bundle of signals between the pad-side nibble stream, the deserializer and
// the core's data response port.
//   nib_i / nib_valid_i / nib_sof_i / nib_ready_o : nibble stream from the pads
//   pdata_o / pvalid_o / pready_i                 : assembled word to the core
//   err_o / clr_err_i                             : sticky frame-error flag and its clear
// The slave modport is the deserializer's view. The master modport is the
// view of the environment (pads + core) that drives the stream and consumes words.
interface nibble_rsp_deserializer_if #(
    parameter int DATA_W = 32,
    parameter int NIB_W  = 4
);
    logic [NIB_W-1:0]  nib_i;
    logic              nib_valid_i;
    logic              nib_sof_i;
    logic              nib_ready_o;
    logic [DATA_W-1:0] pdata_o;
    logic              pvalid_o;
    logic              pready_i;
    logic              err_o;
    logic              clr_err_i;

    modport slave (
        input  nib_i, nib_valid_i, nib_sof_i, pready_i, clr_err_i,
        output nib_ready_o, pdata_o, pvalid_o, err_o
    );

    modport master (
        output nib_i, nib_valid_i, nib_sof_i, pready_i, clr_err_i,
        input  nib_ready_o, pdata_o, pvalid_o, err_o
    );
endinterface

// File: rtl/nibble_rsp_deserializer.sv
// Response-path deserializer: collects NIB_W-bit nibbles from the pads,
// assembles them LSB-nibble-first into DATA_W-bit words and buffers the
// words in a small first-word-fall-through FIFO feeding the core.
// Malformed frames (nibble without start-of-frame in IDLE, restarted frames,
// frames that stall longer than TIMEOUT cycles) are dropped and raise a
// sticky error flag.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset; clears partial and buffered data
//   bus    : slave view of nibble_rsp_deserializer_if (nibble stream in,
//            word out, error flag and its clear)
// DATA_W must be a multiple of NIB_W; DEPTH >= 1; TIMEOUT = 0 disables the
// stall timeout.
module nibble_rsp_deserializer #(
    parameter int DATA_W  = 32,
    parameter int NIB_W   = 4,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_rsp_deserializer_if.slave      bus
);
    localparam int NUM_NIB = DATA_W / NIB_W;
    localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W  = $clog2(DEPTH + 1);

    typedef enum logic {
        S_IDLE,
        S_RECV
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [TMR_W-1:0]   tmr_reg, tmr_next;
    logic [DATA_W-1:0]  word_reg, word_next;
    logic               err_reg, err_next;

    logic [DATA_W-1:0]  mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [FCNT_W-1:0]  fcnt_reg, fcnt_next;

    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               held;
    logic               pop;
    logic               push;
    logic [DATA_W-1:0]  push_data;
    logic [DATA_W-1:0]  word_ins;
    logic               err_set;

    assign fifo_full  = (fcnt_reg == FCNT_W'(DEPTH));
    assign fifo_empty = (fcnt_reg == '0);
    assign accept     = bus.nib_valid_i && !fifo_full;
    // A nibble waiting on back-pressure is not idle time on the link.
    assign held       = bus.nib_valid_i && fifo_full;
    assign pop        = !fifo_empty && bus.pready_i;

    assign bus.nib_ready_o = !fifo_full;
    assign bus.pvalid_o    = !fifo_empty;
    assign bus.pdata_o     = mem_reg[rd_ptr_reg];
    assign bus.err_o       = err_reg;

    // Partial word with the incoming nibble dropped into its slot.
    always_comb begin
        word_ins = word_reg;
        word_ins[int'(cnt_reg) * NIB_W +: NIB_W] = bus.nib_i;
    end

    // ---------------- frame assembly FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            tmr_reg   <= '0;
            word_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tmr_reg   <= tmr_next;
            word_reg  <= word_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmr_next   = tmr_reg;
        word_next  = word_reg;
        push       = 1'b0;
        push_data  = word_ins;
        err_set    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (bus.nib_sof_i) begin
                        word_next = DATA_W'(bus.nib_i);
                        tmr_next  = '0;
                        if (NUM_NIB == 1) begin
                            // Single-nibble words complete on the start nibble.
                            push      = 1'b1;
                            push_data = DATA_W'(bus.nib_i);
                            cnt_next  = '0;
                        end else begin
                            cnt_next   = CNT_W'(1);
                            state_next = S_RECV;
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end

            S_RECV: begin
                if (accept) begin
                    tmr_next = '0;
                    if (bus.nib_sof_i) begin
                        // New frame started before the old one finished.
                        err_set   = 1'b1;
                        word_next = DATA_W'(bus.nib_i);
                        cnt_next  = CNT_W'(1);
                    end else if (cnt_reg == CNT_W'(NUM_NIB - 1)) begin
                        push       = 1'b1;
                        push_data  = word_ins;
                        cnt_next   = '0;
                        state_next = S_IDLE;
                    end else begin
                        word_next = word_ins;
                        cnt_next  = cnt_reg + CNT_W'(1);
                    end
                end else if (!held && (TIMEOUT != 0)) begin
                    // Expiry fires on the idle cycle that brings the timer to
                    // TIMEOUT, so the timer never counts past it.
                    if (tmr_reg >= TMR_W'(TIMEOUT - 1)) begin
                        err_set    = 1'b1;
                        cnt_next   = '0;
                        tmr_next   = '0;
                        state_next = S_IDLE;
                    end else begin
                        tmr_next = tmr_reg + TMR_W'(1);
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                tmr_next   = '0;
            end
        endcase

        // A new error outranks a simultaneous clear.
        if (err_set) begin
            err_next = 1'b1;
        end else if (bus.clr_err_i) begin
            err_next = 1'b0;
        end else begin
            err_next = err_reg;
        end
    end

    // ---------------- output FIFO (first-word fall-through) ----------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        fcnt_next   = fcnt_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fcnt_next = fcnt_reg + FCNT_W'(1);
            2'b01:   fcnt_next = fcnt_reg - FCNT_W'(1);
            default: fcnt_next = fcnt_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fcnt_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            fcnt_reg   <= fcnt_next;
        end
    end
endmodule

// File: tb/tb_nibble_rsp_deserializer.sv
module tb_nibble_rsp_deserializer;
    localparam int DATA_W = 32;
    localparam int NIB_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_rsp_deserializer_if #(.DATA_W(DATA_W), .NIB_W(NIB_W)) bus ();

    nibble_rsp_deserializer #(
        .DATA_W (DATA_W),
        .NIB_W  (NIB_W),
        .DEPTH  (2),
        .TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: a word transfers at the next rising edge when pvalid && pready
    // hold at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.pvalid_o && bus.pready_i) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_word: got 0x%08h, expected no word", bus.pdata_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    $display("word out 0x%08h (expected 0x%08h)", bus.pdata_o, mon_exp);
                    check("word_out", bus.pdata_o, mon_exp);
                end
            end
        end
    end

    // Present one nibble until it is accepted (bounded), then drop valid.
    task automatic send_nib(input logic [3:0] n, input logic s);
        int waited = 0;
        bit acc;
        bus.nib_i       = n;
        bus.nib_sof_i   = s;
        bus.nib_valid_i = 1'b1;
        do begin
            acc = bus.nib_ready_o;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 200);
        if (!acc) begin
            chk_cnt++;
            $display("FAIL nib_accept_timeout: nibble 0x%0h not accepted, expected accept", n);
        end
        bus.nib_valid_i = 1'b0;
        bus.nib_sof_i   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back(w);
        $display("send word 0x%08h", w);
        for (int i = 0; i < 8; i++) send_nib(w[i*4 +: 4], (i == 0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        bus.clr_err_i = 1'b1;
        idle(1);
        bus.clr_err_i = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        bus.nib_i       = '0;
        bus.nib_valid_i = 1'b0;
        bus.nib_sof_i   = 1'b0;
        bus.pready_i    = 1'b0;
        bus.clr_err_i   = 1'b0;

        // Reset state (an edge has passed with reset held)
        #7;
        check("rst_pvalid", 32'(bus.pvalid_o), 32'd0);
        check("rst_pdata", bus.pdata_o, 32'h0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_nib_ready", 32'(bus.nib_ready_o), 32'd1);
        #15 rst_n = 1'b1;
        idle(1);

        // 1: DEADBEEF with one-cycle latency
        bus.pready_i = 1'b1;
        w = 32'hDEADBEEF;
        exp_q.push_back(w);
        $display("send word 0x%08h", w);
        for (int i = 0; i < 8; i++) begin
            send_nib(w[i*4 +: 4], (i == 0));
            if (i == 6) check("t1_pvalid_before_last", 32'(bus.pvalid_o), 32'd0);
        end
        check("t1_pvalid", 32'(bus.pvalid_o), 32'd1);
        check("t1_pdata", bus.pdata_o, 32'hDEADBEEF);
        check("t1_err", 32'(bus.err_o), 32'd0);
        idle(2);

        // 2: back-pressure with a full FIFO, order preserved
        bus.pready_i = 1'b0;
        send_word(32'hA5A50001);
        send_word(32'h0000FFFF);
        check("t2_nib_ready_full", 32'(bus.nib_ready_o), 32'd0);
        check("t2_head", bus.pdata_o, 32'hA5A50001);
        fork
            send_word(32'h1234ABCD);
            begin
                idle(5);
                check("t2_head_stable", bus.pdata_o, 32'hA5A50001);
                bus.pready_i = 1'b1;
            end
        join
        idle(5);

        // 3: stray nibble in IDLE, clear, set-wins-over-clear
        send_nib(4'h5, 1'b0);
        check("t3_err_set", 32'(bus.err_o), 32'd1);
        check("t3_no_pvalid", 32'(bus.pvalid_o), 32'd0);
        clr_pulse();
        check("t3_err_clr", 32'(bus.err_o), 32'd0);
        bus.clr_err_i = 1'b1;
        send_nib(4'h5, 1'b0);
        bus.clr_err_i = 1'b0;
        check("t3_set_wins", 32'(bus.err_o), 32'd1);
        clr_pulse();
        check("t3_err_clr2", 32'(bus.err_o), 32'd0);

        // 4: sof reasserted on nibble 5 restarts the frame
        send_nib(4'h1, 1'b1);
        send_nib(4'h2, 1'b0);
        send_nib(4'h3, 1'b0);
        send_nib(4'h4, 1'b0);
        send_word(32'h12345678);
        check("t4_err", 32'(bus.err_o), 32'd1);
        idle(3);
        clr_pulse();

        // 5: stall timeout after 16 idle cycles
        send_nib(4'h9, 1'b1);
        send_nib(4'h9, 1'b0);
        send_nib(4'h9, 1'b0);
        idle(15);
        check("t5_err_at_15", 32'(bus.err_o), 32'd0);
        idle(1);
        check("t5_err_at_16", 32'(bus.err_o), 32'd1);
        clr_pulse();
        send_word(32'hCAFE0123);
        check("t5_err_after_word", 32'(bus.err_o), 32'd0);
        idle(3);

        // 6: async reset with FIFO full, then mid-frame
        bus.pready_i = 1'b0;
        send_word(32'h11112222);
        send_word(32'h33334444);
        check("t6_full", 32'(bus.nib_ready_o), 32'd0);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_pvalid", 32'(bus.pvalid_o), 32'd0);
        check("t6_rst_nib_ready", 32'(bus.nib_ready_o), 32'd1);
        check("t6_rst_pdata", bus.pdata_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.pready_i = 1'b1;
        idle(1);
        send_nib(4'h7, 1'b1);
        send_nib(4'h7, 1'b0);
        send_nib(4'h7, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst2_pvalid", 32'(bus.pvalid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_word(32'h0BADF00D);
        check("t6_err_after_word", 32'(bus.err_o), 32'd0);
        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
